// File: rtl/seconds_timer_ctrl.sv
// One-second prescaler and two-digit BCD up/down seconds counter that feeds the display decoder.
// Optional build macro DONE_BLINK_EN: blink the terminal count while in DONE (blank phase drives 4'hF).
module seconds_timer_ctrl #(
    parameter int TICK_CYCLES = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] load_unidades,
    input  logic [3:0] load_decenas,
    input  logic       down,
    output logic [3:0] segundos_unidades,
    output logic [3:0] segundos_decenas,
    output logic       running,
    output logic       tick,
    output logic       done
);

    localparam int PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t        state, state_n;
    logic [3:0]    cnt_u, cnt_t, cnt_u_n, cnt_t_n;
    logic [PW-1:0] pre, pre_n;
    logic          dir, dir_n;
    logic          tick_n;
    logic [3:0]    inc_u, inc_t, dec_u, dec_t;
    logic [3:0]    ld_u, ld_t;
    logic [3:0]    disp_u, disp_t;
    logic          cnt_zero, cnt_max;

`ifdef DONE_BLINK_EN
    localparam logic [PW-1:0] HALF_LAST = PW'(TICK_CYCLES / 2 - 1);
    logic blank, blank_n;
`endif

    // BCD neighbours of the current count and clamped load digits.
    always_comb begin
        inc_u    = (cnt_u == 4'd9) ? 4'd0 : cnt_u + 4'd1;
        inc_t    = (cnt_u == 4'd9) ? cnt_t + 4'd1 : cnt_t;
        dec_u    = (cnt_u == 4'd0) ? 4'd9 : cnt_u - 4'd1;
        dec_t    = (cnt_u == 4'd0) ? cnt_t - 4'd1 : cnt_t;
        ld_u     = (load_unidades > 4'd9) ? 4'd9 : load_unidades;
        ld_t     = (load_decenas > 4'd9) ? 4'd9 : load_decenas;
        cnt_zero = (cnt_u == 4'd0) && (cnt_t == 4'd0);
        cnt_max  = (cnt_u == 4'd9) && (cnt_t == 4'd9);
    end

    always_comb begin
        state_n = state;
        cnt_u_n = cnt_u;
        cnt_t_n = cnt_t;
        pre_n   = pre;
        dir_n   = dir;
        tick_n  = 1'b0;
`ifdef DONE_BLINK_EN
        blank_n = (state == DONE) ? blank : 1'b0;
`endif
        if (clear) begin
            state_n = IDLE;
            cnt_u_n = 4'd0;
            cnt_t_n = 4'd0;
            pre_n   = '0;
`ifdef DONE_BLINK_EN
            blank_n = 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pause) begin
                        state_n = IDLE;
                    end else if (start) begin
                        dir_n = down;
                        pre_n = '0;
                        // A run that is already at its terminal value has nothing to count.
                        if ((down && cnt_zero) || (!down && cnt_max)) state_n = DONE;
                        else                                        state_n = RUN;
                    end else if (load) begin
                        cnt_u_n = ld_u;
                        cnt_t_n = ld_t;
                    end
                end
                RUN: begin
                    if (pre == PRE_LAST) begin
                        pre_n  = '0;
                        tick_n = 1'b1;
                        if (dir) begin
                            cnt_u_n = dec_u;
                            cnt_t_n = dec_t;
                            if (dec_u == 4'd0 && dec_t == 4'd0) state_n = DONE;
                        end else begin
                            cnt_u_n = inc_u;
                            cnt_t_n = inc_t;
                            if (inc_u == 4'd9 && inc_t == 4'd9) state_n = DONE;
                        end
                    end else begin
                        pre_n = pre + PW'(1);
                    end
                    // The tick on this edge is already applied above; pause only redirects the state.
                    if (pause && state_n == RUN) state_n = PAUSED;
                end
                PAUSED: begin
                    if (!pause && start) state_n = RUN;
                end
                DONE: begin
`ifdef DONE_BLINK_EN
                    if (pre == HALF_LAST) begin
                        pre_n   = '0;
                        blank_n = ~blank;
                    end else begin
                        pre_n = pre + PW'(1);
                    end
`endif
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_comb begin
        disp_u = cnt_u_n;
        disp_t = cnt_t_n;
`ifdef DONE_BLINK_EN
        if (blank_n) begin
            disp_u = 4'hF;
            disp_t = 4'hF;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            cnt_u             <= 4'd0;
            cnt_t             <= 4'd0;
            pre               <= '0;
            dir               <= 1'b0;
            segundos_unidades <= 4'd0;
            segundos_decenas  <= 4'd0;
            running           <= 1'b0;
            tick              <= 1'b0;
            done              <= 1'b0;
`ifdef DONE_BLINK_EN
            blank             <= 1'b0;
`endif
        end else begin
            state             <= state_n;
            cnt_u             <= cnt_u_n;
            cnt_t             <= cnt_t_n;
            pre               <= pre_n;
            dir               <= dir_n;
            segundos_unidades <= disp_u;
            segundos_decenas  <= disp_t;
            running           <= (state_n == RUN);
            tick              <= tick_n;
            done              <= (state_n == DONE);
`ifdef DONE_BLINK_EN
            blank             <= blank_n;
`endif
        end
    end

endmodule
